// File: rtl/lfsr_stats_pkg.sv
// Shared types and constants for the LFSR statistics sequencer.
// Optional build macro: LFSR_STATS_CHECK_EN (adds chk_err to the top).
package lfsr_stats_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_CAPTURE,
    ST_SHOW
  } state_e;

  localparam logic [1:0] SEL_ONES  = 2'd0;
  localparam logic [1:0] SEL_ZEROS = 2'd1;
  localparam logic [1:0] SEL_HITS  = 2'd2;

  // An all-zero seed would lock the LFSR up.
  localparam int SEED_ZERO_SUB = 1;

  function automatic logic [1:0] next_sel(
    input logic [1:0] s
  );
    return (s == SEL_HITS) ? SEL_ONES : s + 2'd1;
  endfunction

endpackage

// File: rtl/lfsr_stats_disp.sv
// Result display rotation: dwell timer, selector and LED mux.
// Optional build macro: none used in this file.
module lfsr_stats_disp
  import lfsr_stats_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int DWELL = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] ones_i,
  input  logic [CNT_W-1:0] zeros_i,
  input  logic [CNT_W-1:0] hits_i,
  output logic [1:0]       sel_o,
  output logic [15:0]      led_o
);

  localparam int TW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [TW-1:0] LAST = TW'(DWELL - 1);

  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      sel_q   <= SEL_ONES;
    end else begin
      timer_q <= timer_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    timer_d = timer_q;
    sel_d   = sel_q;
    if (clr_i) begin
      timer_d = '0;
      sel_d   = SEL_ONES;
    end else if (en_i) begin
      if (timer_q == LAST) begin
        timer_d = '0;
        sel_d   = next_sel(sel_q);
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_comb begin
    pick = ones_i;
    unique case (sel_q)
      SEL_ZEROS: pick = zeros_i;
      SEL_HITS:  pick = hits_i;
      default:   pick = ones_i;
    endcase
  end

  assign sel_o = sel_q;
  assign led_o = 16'(pick);

endmodule

// File: rtl/lfsr_stats_seq.sv
// Measurement-window sequencer for an LFSR bit-statistics counter set.
// Optional build macro: LFSR_STATS_CHECK_EN adds chk_err (sum check).
module lfsr_stats_seq
  import lfsr_stats_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int DWELL  = 50_000_000,
  parameter int SEED_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  window_len,
  input  logic [SEED_W-1:0] seed_in,
  input  logic [CNT_W-1:0]  ones_in,
  input  logic [CNT_W-1:0]  zeros_in,
  input  logic [CNT_W-1:0]  hits_in,
  output logic              lfsr_load,
  output logic [SEED_W-1:0] seed_out,
  output logic              lfsr_en,
  output logic              cnt_clr,
  output logic              busy,
  output logic              done,
`ifdef LFSR_STATS_CHECK_EN
  output logic              chk_err,
`endif
  output logic [1:0]        disp_sel,
  output logic [15:0]       led_out
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  n_q, step_q;
  logic [SEED_W-1:0] seed_q;
  logic [CNT_W-1:0]  res_ones_q, res_zeros_q, res_hits_q;
  logic              load_q, clr_q, en_q;
  logic              load_d, clr_d, en_d;
  logic              accept, capture, disp_en;

  assign accept  = start && !abort &&
                   (state_q == ST_IDLE || state_q == ST_SHOW);
  assign capture = (state_q == ST_CAPTURE) && !abort;
  assign disp_en = (state_q == ST_SHOW) && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      load_q  <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE,
        ST_SHOW:    if (start) state_d = ST_SEED;
        ST_SEED:    state_d = ST_CLEAR;
        ST_CLEAR:   state_d = ST_RUN;
        ST_RUN:     if (step_q == n_q) state_d = ST_SETTLE;
        ST_SETTLE:  state_d = ST_CAPTURE;
        ST_CAPTURE: state_d = ST_SHOW;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Strobes decode the next state so they are flops aligned to it.
  always_comb begin
    load_d = (state_d == ST_SEED);
    clr_d  = (state_d == ST_CLEAR);
    en_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q         <= '0;
      seed_q      <= '0;
      step_q      <= '0;
      res_ones_q  <= '0;
      res_zeros_q <= '0;
      res_hits_q  <= '0;
    end else begin
      if (accept) begin
        n_q    <= (window_len == '0) ? CNT_W'(1) : window_len;
        seed_q <= seed_in;
      end
      if (state_q == ST_CLEAR) begin
        step_q <= CNT_W'(1);
      end else if (state_q == ST_RUN && step_q != n_q) begin
        step_q <= step_q + CNT_W'(1);
      end
      if (capture) begin
        res_ones_q  <= ones_in;
        res_zeros_q <= zeros_in;
        res_hits_q  <= hits_in;
      end
    end
  end

`ifdef LFSR_STATS_CHECK_EN
  logic [CNT_W+1:0] sum;
  logic             chk_q;

  assign sum = {2'b00, ones_in} + {2'b00, zeros_in} +
               {2'b00, hits_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= 1'b0;
    end else if (accept) begin
      chk_q <= 1'b0;
    end else if (capture) begin
      chk_q <= (sum != {2'b00, n_q});
    end
  end

  assign chk_err = chk_q;
`endif

  assign lfsr_load = load_q;
  assign cnt_clr   = clr_q;
  assign lfsr_en   = en_q;
  assign seed_out  = (seed_q == '0) ? SEED_W'(SEED_ZERO_SUB) : seed_q;
  assign busy      = !(state_q == ST_IDLE || state_q == ST_SHOW);
  assign done      = capture;

  lfsr_stats_disp #(
    .CNT_W (CNT_W),
    .DWELL (DWELL)
  ) u_disp (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (capture),
    .en_i    (disp_en),
    .ones_i  (res_ones_q),
    .zeros_i (res_zeros_q),
    .hits_i  (res_hits_q),
    .sel_o   (disp_sel),
    .led_o   (led_out)
  );

endmodule

// File: tb/tb_lfsr_stats_seq.sv
// Directed bench for lfsr_stats_seq (DWELL=4, CNT_W=16).
// Optional build macro: LFSR_STATS_CHECK_EN enables the chk_err test.
module tb_lfsr_stats_seq;

  localparam int CW = 16;
  localparam int DW = 4;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] window_len = '0;
  logic [SW-1:0] seed_in = '0;
  logic [CW-1:0] ones_in = '0;
  logic [CW-1:0] zeros_in = '0;
  logic [CW-1:0] hits_in = '0;
  logic          lfsr_load, lfsr_en, cnt_clr, busy, done;
  logic [SW-1:0] seed_out;
  logic [1:0]    disp_sel;
  logic [15:0]   led_out;
`ifdef LFSR_STATS_CHECK_EN
  logic          chk_err;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lfsr_stats_seq #(
    .CNT_W  (CW),
    .DWELL  (DW),
    .SEED_W (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .window_len (window_len),
    .seed_in    (seed_in),
    .ones_in    (ones_in),
    .zeros_in   (zeros_in),
    .hits_in    (hits_in),
    .lfsr_load  (lfsr_load),
    .seed_out   (seed_out),
    .lfsr_en    (lfsr_en),
    .cnt_clr    (cnt_clr),
    .busy       (busy),
    .done       (done),
`ifdef LFSR_STATS_CHECK_EN
    .chk_err    (chk_err),
`endif
    .disp_sel   (disp_sel),
    .led_out    (led_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [CW-1:0] l, input logic [SW-1:0] s);
    window_len = l;
    seed_in    = s;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Samples one cycle at a time until done; returns in first SHOW cycle.
  task automatic observe(input int max, output int ld, output int cl,
                         output int en, output int last_en,
                         output int done_at, output int excl);
    ld = 0; cl = 0; en = 0; last_en = -1; done_at = -1; excl = 0;
    for (int i = 0; i < max; i++) begin
      ld += int'(lfsr_load);
      cl += int'(cnt_clr);
      en += int'(lfsr_en);
      if (lfsr_en) last_en = i;
      if (int'(lfsr_load) + int'(cnt_clr) + int'(lfsr_en) > 1) excl++;
      if (done) done_at = i;
      tick();
      if (done_at >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++;
    if ({lfsr_load, cnt_clr, lfsr_en} !== 3'b000) begin
      bad++;
      $display("FAIL reset_strobes got=%b exp=000",
               {lfsr_load, cnt_clr, lfsr_en});
    end
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_busy_done got=%b exp=00", {busy, done});
    end
    total++;
    if (disp_sel !== 2'd0 || led_out !== 16'd0) begin
      bad++;
      $display("FAIL reset_disp got sel=%0d led=%0h exp sel=0 led=0",
               disp_sel, led_out);
    end
`ifdef LFSR_STATS_CHECK_EN
    total++;
    if (chk_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_chk got=%b exp=0", chk_err);
    end
`endif
  endtask

  task automatic test_basic();
    int ld, cl, en, le, da, ex;
    logic [15:0] exp_led;
    logic [1:0]  exp_sel;
    ones_in = 16'd5; zeros_in = 16'd2; hits_in = 16'd1;
    go(16'd8, 16'hACE1);
    total++;
    if (busy !== 1'b1 || seed_out !== 16'hACE1) begin
      bad++;
      $display("FAIL basic_seed got busy=%b seed=%0h exp busy=1 seed=ace1",
               busy, seed_out);
    end
    observe(40, ld, cl, en, le, da, ex);
    total++;
    if (ld !== 1 || cl !== 1) begin
      bad++;
      $display("FAIL basic_load_clr got ld=%0d cl=%0d exp 1 1", ld, cl);
    end
    total++;
    if (en !== 8) begin
      bad++;
      $display("FAIL basic_en_len got=%0d exp=8", en);
    end
    total++;
    if (da < 0 || da - le !== 2) begin
      bad++;
      $display("FAIL basic_done_lat got done_at=%0d last_en=%0d exp gap 2",
               da, le);
    end
    total++;
    if (ex !== 0) begin
      bad++;
      $display("FAIL basic_excl got=%0d exp=0", ex);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_show_busy got=%b exp=0", busy);
    end
    for (int k = 0; k < 16; k++) begin
      exp_sel = 2'((k / 4) % 3);
      exp_led = (exp_sel == 2'd0) ? 16'd5 :
                (exp_sel == 2'd1) ? 16'd2 : 16'd1;
      total++;
      if (led_out !== exp_led || disp_sel !== exp_sel) begin
        bad++;
        $display("FAIL rotate_%0d got sel=%0d led=%0d exp sel=%0d led=%0d",
                 k, disp_sel, led_out, exp_sel, exp_led);
      end
      tick();
    end
  endtask

  task automatic test_zero();
    int ld, cl, en, le, da, ex;
    ones_in = 16'd1; zeros_in = 16'd0; hits_in = 16'd0;
    go(16'd0, 16'd0);
    total++;
    if (seed_out !== 16'd1 || lfsr_load !== 1'b1) begin
      bad++;
      $display("FAIL zero_seed got seed=%0h load=%b exp seed=1 load=1",
               seed_out, lfsr_load);
    end
    observe(40, ld, cl, en, le, da, ex);
    total++;
    if (en !== 1 || da < 0) begin
      bad++;
      $display("FAIL zero_len got en=%0d done_at=%0d exp en=1 done", en, da);
    end
    total++;
    if (led_out !== 16'd1) begin
      bad++;
      $display("FAIL zero_led got=%0d exp=1", led_out);
    end
  endtask

  task automatic test_abort();
    int dn, lbad;
    ones_in = 16'd9; zeros_in = 16'd9; hits_in = 16'd9;
    go(16'd10, 16'd5);
    tick();
    tick();
    tick();
    tick();
    total++;
    if (lfsr_en !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre_en got=%b exp=1", lfsr_en);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (lfsr_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_stop got en=%b busy=%b exp 0 0", lfsr_en, busy);
    end
    dn = 0; lbad = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dn++;
      if (led_out !== 16'd1) lbad++;
      tick();
    end
    total++;
    if (dn !== 0 || lbad !== 0) begin
      bad++;
      $display("FAIL abort_hold got done=%0d led_changes=%0d exp 0 0",
               dn, lbad);
    end
  endtask

  task automatic test_start_abort();
    int ld, en, da, ex;
    ones_in = 16'd3; zeros_in = 16'd2; hits_in = 16'd1;
    go(16'd6, 16'd7);
    ld = 0; en = 0; da = -1; ex = 0;
    for (int i = 0; i < 40; i++) begin
      start = (i == 3);
      ld += int'(lfsr_load);
      en += int'(lfsr_en);
      if (done) da = i;
      tick();
      if (da >= 0) break;
    end
    start = 1'b0;
    total++;
    if (ld !== 1 || en !== 6 || da < 0) begin
      bad++;
      $display("FAIL run_start_ignored got ld=%0d en=%0d done_at=%0d exp 1 6 >=0",
               ld, en, da);
    end
    total++;
    if (led_out !== 16'd3) begin
      bad++;
      $display("FAIL run_start_led got=%0d exp=3", led_out);
    end
    go(16'd6, 16'd7);
    tick();
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || lfsr_en !== 1'b0) begin
      bad++;
      $display("FAIL both_idle got busy=%b en=%b exp 0 0", busy, lfsr_en);
    end
    ld = 0;
    for (int i = 0; i < 6; i++) begin
      ld += int'(lfsr_load) + int'(busy);
      tick();
    end
    total++;
    if (ld !== 0) begin
      bad++;
      $display("FAIL both_start_dropped got=%0d exp=0", ld);
    end
  endtask

`ifdef LFSR_STATS_CHECK_EN
  task automatic test_chk();
    int ld, cl, en, le, da, ex;
    ones_in = 16'd4; zeros_in = 16'd3; hits_in = 16'd0;
    go(16'd8, 16'd1);
    observe(40, ld, cl, en, le, da, ex);
    total++;
    if (chk_err !== 1'b1) begin
      bad++;
      $display("FAIL chk_bad_sum got=%b exp=1", chk_err);
    end
    hits_in = 16'd1;
    go(16'd8, 16'd1);
    total++;
    if (chk_err !== 1'b0) begin
      bad++;
      $display("FAIL chk_clear_on_start got=%b exp=0", chk_err);
    end
    observe(40, ld, cl, en, le, da, ex);
    total++;
    if (chk_err !== 1'b0) begin
      bad++;
      $display("FAIL chk_good_sum got=%b exp=0", chk_err);
    end
  endtask
`endif

  task automatic test_rst_run();
    ones_in = 16'd7; zeros_in = 16'd1; hits_in = 16'd2;
    go(16'd10, 16'd1);
    tick();
    tick();
    total++;
    if (lfsr_en !== 1'b1) begin
      bad++;
      $display("FAIL rst_run_pre got=%b exp=1", lfsr_en);
    end
    rst = 1'b1;
    tick();
    total++;
    if (lfsr_en !== 1'b0 || busy !== 1'b0 ||
        led_out !== 16'd0 || disp_sel !== 2'd0) begin
      bad++;
      $display("FAIL rst_run got en=%b busy=%b led=%0d sel=%0d exp 0 0 0 0",
               lfsr_en, busy, led_out, disp_sel);
    end
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (lfsr_en !== 1'b0 || led_out !== 16'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_capture got en=%b led=%0d done=%b exp 0 0 0",
               lfsr_en, led_out, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_abort();
    test_start_abort();
`ifdef LFSR_STATS_CHECK_EN
    test_chk();
`endif
    test_rst_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_stats_seq.md
LFSR_STATS_SEQ -- requirements
Module: lfsr_stats_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of window length and result counts.
REQ-002 SHALL have parameter DWELL, default 50_000_000, cycles each result is shown on LEDs.
REQ-003 SHALL have parameter SEED_W, default 16, LFSR seed width.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a measurement window.
REQ-007 SHALL have port abort  in  1  stop the current window immediately.
REQ-008 SHALL have port window_len  in  CNT_W  LFSR steps per window, sampled on accepted start.
REQ-009 SHALL have port seed_in  in  SEED_W  LFSR seed, sampled on accepted start.
REQ-010 SHALL have port ones_in, zeros_in, hits_in  in  CNT_W each  live counter values; each is 0 after cnt_clr.
REQ-011 SHALL have port lfsr_load  out  1; seed_out  out  SEED_W; lfsr_en  out  1; cnt_clr  out  1.
REQ-012 SHALL have port busy  out  1; done  out  1 (one-cycle pulse); disp_sel  out  2; led_out  out  16.

Function
REQ-013 SHALL implement states IDLE, SEED, CLEAR, RUN, SETTLE, CAPTURE, SHOW.
REQ-014 IDLE: start -> SEED; window_len and seed_in latched that cycle; busy=1 from next cycle.
REQ-015 SEED: one cycle, lfsr_load=1, seed_out=latched seed, or 1 if latched seed is 0; -> CLEAR.
REQ-016 CLEAR: one cycle, cnt_clr=1; -> RUN.
REQ-017 RUN: lfsr_en=1 for exactly N cycles, N = latched window_len, or 1 if it is 0; -> SETTLE.
REQ-018 SETTLE: one cycle, lfsr_en=0, so counters absorb the final sample; -> CAPTURE.
REQ-019 CAPTURE: ones_in, zeros_in, hits_in copied into result registers; done=1 this cycle; -> SHOW.
REQ-020 SHOW: busy=0; disp_sel steps 0->1->2->0, each held DWELL cycles; led_out = low 16 bits of result[disp_sel] (0 ones, 1 zeros, 2 hits).
REQ-021 start in SHOW or IDLE is accepted; start in SEED..CAPTURE is ignored.
REQ-022 abort in any state except IDLE -> IDLE next cycle; lfsr_en=0 from that edge; result registers and led_out unchanged; done not pulsed.
REQ-023 abort and start in the same cycle: abort wins, start dropped.
REQ-024 RUN step counter SHALL be CNT_W bits and not wrap; N = 2^CNT_W-1 completes normally.
REQ-025 lfsr_load, cnt_clr, lfsr_en SHALL be mutually exclusive and registered outputs.

Reset
REQ-026 rst SHALL force IDLE, all strobes 0, busy=0, done=0, disp_sel=0, led_out=0, result registers 0, dwell timer 0.
REQ-027 rst mid-RUN SHALL deassert lfsr_en on the same edge; no capture occurs.

Configuration
REQ-028 With LFSR_STATS_CHECK_EN defined, SHALL add output chk_err (1 bit): set in CAPTURE if ones_in+zeros_in+hits_in != N (CNT_W+2-bit sum); held until next accepted start or rst.
REQ-029 Without LFSR_STATS_CHECK_EN, chk_err port and adder SHALL not exist.

Structure
REQ-030 Shared package lfsr_stats_pkg SHALL hold the state enum, disp_sel encodings (SEL_ONES=0, SEL_ZEROS=1, SEL_HITS=2), and the seed-zero substitute constant.
REQ-031 Display rotation (dwell timer + disp_sel + led mux) SHALL be sub-module lfsr_stats_disp.

Verification
REQ-032 window_len=8, seed=0xACE1, start -> lfsr_load 1 cycle, cnt_clr 1 cycle, lfsr_en high exactly 8 cycles, done 2 cycles after lfsr_en falls.
REQ-033 Model counters ones=5, zeros=2, hits=1 at capture, DWELL=4 -> led_out 5,2,1,5 each held 4 cycles.
REQ-034 seed_in=0, window_len=0 -> seed_out=1, lfsr_en high 1 cycle.
REQ-035 abort on RUN cycle 3 of 10 -> lfsr_en low next cycle, state IDLE, no done, led_out keeps prior value.
REQ-036 start+abort same cycle in RUN -> IDLE; start during RUN alone -> ignored, window completes.
REQ-037 With LFSR_STATS_CHECK_EN, N=8, counters 4+3+0 -> chk_err=1; 4+3+1 -> chk_err=0.
